mux_arb_2x1: RTL and testbench
==============================

MUX_ARB_2X1 -- requirements
Module: mux_arb_2x1

Interface
REQ-001 Parameter: WIDTH, default 8, data width of both sources and the output.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 a_valid  input  1  source A offers a_data this cycle.
REQ-005 a_data  input  WIDTH  source A payload.
REQ-006 a_ready  output  1  source A payload accepted this cycle.
REQ-007 b_valid  input  1  source B offers b_data this cycle.
REQ-008 b_data  input  WIDTH  source B payload.
REQ-009 b_ready  output  1  source B payload accepted this cycle.
REQ-010 sel  output  1  mux select for the current cycle; 0 = A, 1 = B.
REQ-011 out_valid  output  1  output register holds a valid word.
REQ-012 out_data  output  WIDTH  registered selected payload.
REQ-013 out_src  output  1  source of out_data; 0 = A, 1 = B.
REQ-014 out_ready  input  1  consumer accepts out_data this cycle.
REQ-015 gnt_cnt_a, gnt_cnt_b  output  8 each  grants issued to A and B.

Function
REQ-016 The output register SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 load SHALL be asserted when (EMPTY or out_ready) and (a_valid or b_valid).
REQ-018 Winner SHALL be the only valid source, or, when both are valid, the source indicated by prio (0 = A, 1 = B).
REQ-019 sel SHALL equal the winner when load=1 and SHALL hold its last value otherwise.
REQ-020 a_ready SHALL equal load and winner==A; b_ready SHALL equal load and winner==B; at most one ready SHALL be high per cycle.
REQ-021 On load, out_data SHALL take the winner's data and out_src SHALL take the winner, visible next cycle (latency 1), and the FSM SHALL go to FULL.
REQ-022 In FULL with out_ready=1 and no load, the FSM SHALL go to EMPTY; out_data SHALL keep its value.
REQ-023 In FULL with out_ready=0, out_data, out_src and out_valid SHALL remain stable and both readys SHALL be 0.
REQ-024 In FULL with out_ready=1 and load=1, the new word SHALL replace the old one in the same cycle, giving zero-bubble throughput of 1 word per cycle.
REQ-025 After every grant, prio SHALL become the non-winner; with no grant, prio SHALL hold.
REQ-026 A single valid source SHALL be granted on every load regardless of prio.
REQ-027 gnt_cnt_x SHALL increment by 1 on each grant to x and wrap from 255 to 0.
REQ-028 Ready outputs MAY depend combinationally on valids and out_ready; valids SHALL NOT depend on readys.

Reset
REQ-029 While rst=1, the following SHALL hold:
- FSM at EMPTY, with out_valid=0, out_data=0, out_src=0, sel=0, prio=0 (A first).
- gnt_cnt_a=0 and gnt_cnt_b=0.
- a_ready=0 and b_ready=0.
REQ-030 Reset asserted mid-transfer SHALL discard the held word; no grant or counter update SHALL occur in a reset cycle.

Structure
REQ-031 Package mux_arb_pkg SHALL hold the WIDTH default, the FSM state typedef (EMPTY, FULL) and the source typedef (SRC_A=0, SRC_B=1).
REQ-032 The two-way round-robin decision (valids, prio -> winner, any) SHALL be a combinational sub-module rr_arb2.
REQ-033 The datapath selection SHALL use the existing mux_2x1 with s driven by sel.

Verification
REQ-034 Reset sequence: rst=1 for 2 cycles, then 0 -> all outputs 0, FSM EMPTY.
REQ-035 Both sources valid for 4 cycles with out_ready=1, a_data=8'h11, b_data=8'h22 -> out_data sequence 11,22,11,22 with out_src 0,1,0,1 and gnt_cnt_a=gnt_cnt_b=2.
REQ-036 A only valid (8'hA5), out_ready=0 for 3 cycles -> out_data=A5 stable, a_ready=0 after the first load; out_ready=1 -> next word loaded the same cycle.
REQ-037 300 grants to A only -> gnt_cnt_a=300 mod 256=44, gnt_cnt_b=0.
REQ-038 rst=1 while FULL with out_data=8'h3C -> next cycle out_valid=0, out_data=0, prio=0, and the next contention grants A first.
REQ-039 Check every cycle: a_ready and b_ready never both 1; no ready while FULL and out_ready=0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the two-source round-robin output mux.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mux_arb_pkg;

  localparam int WIDTH_DEF = 8;

  // Output register occupancy; kept as plain constants so older tools can read them.
  typedef logic [0:0] state_t;
  localparam state_t EMPTY = 1'b0;
  localparam state_t FULL  = 1'b1;

  // Source identity; the encoding doubles as the mux select value.
  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

endpackage

// File: rtl/mux_arb_2x1_if.sv
// Bundle of the two source channels, the output channel and grant counters.
// Latency: none (wiring only).
// Backpressure: carries valid/ready for sources and out_valid/out_ready for the sink.
interface mux_arb_2x1_if #(
  parameter int WIDTH = mux_arb_pkg::WIDTH_DEF
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;
  logic [7:0]       gnt_cnt_a;
  logic [7:0]       gnt_cnt_b;

  // Producer/consumer side that drives the sources and the sink ready.
  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, sel, out_valid, out_data, out_src, gnt_cnt_a, gnt_cnt_b
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, sel, out_valid, out_data, out_src, gnt_cnt_a, gnt_cnt_b
  );
endinterface

// File: rtl/mux_2x1.sv
// Plain two-input word multiplexer; s=0 selects a, s=1 selects b.
// Latency: combinational.
// Backpressure: none.
module mux_2x1 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin decision: picks the lone requester, or prio on contention.
// Latency: combinational.
// Backpressure: none; the caller decides whether the decision is used.
module rr_arb2
  import mux_arb_pkg::*;
(
  input  logic a_valid,
  input  logic b_valid,
  input  src_t prio,
  output src_t winner,
  output logic any
);

  // Contention goes to prio; otherwise the only requester wins (A when idle).
  always_comb begin
    winner = SRC_A;
    any    = a_valid | b_valid;
    if (a_valid && b_valid) begin
      winner = prio;
    end else if (b_valid) begin
      winner = SRC_B;
    end
  end

endmodule

// File: rtl/mux_arb_2x1.sv
// Round-robin merge of two valid/ready sources into one registered output word.
// Latency: 1 cycle from grant to out_valid/out_data; full rate, no bubble.
// Backpressure: a held word with out_ready=0 blocks all grants until it drains.
module mux_arb_2x1
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  mux_arb_2x1_if.slave bus
);

  state_t           state;
  src_t             prio;
  src_t             winner;
  logic             any;
  logic             load;
  logic             sel_q;
  logic             sel_now;
  logic [WIDTH-1:0] mux_y;
  logic [WIDTH-1:0] data_q;
  logic             src_q;
  logic [7:0]       cnt_a;
  logic [7:0]       cnt_b;

  rr_arb2 u_arb (
    .a_valid (bus.a_valid),
    .b_valid (bus.b_valid),
    .prio    (prio),
    .winner  (winner),
    .any     (any)
  );

  mux_2x1 #(.WIDTH(WIDTH)) u_mux (
    .a (bus.a_data),
    .b (bus.b_data),
    .s (sel_now),
    .y (mux_y)
  );

  // Accept a word when the register is free or draining this cycle; never in reset.
  always_comb begin
    load    = 1'b0;
    sel_now = sel_q;
    if (!rst) begin
      load = ((state == EMPTY) || bus.out_ready) && any;
      if (load) begin
        sel_now = (winner == SRC_B);
      end
    end else begin
      sel_now = 1'b0;
    end
  end

  assign bus.a_ready   = load && (winner == SRC_A);
  assign bus.b_ready   = load && (winner == SRC_B);
  assign bus.sel       = sel_now;
  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
  assign bus.gnt_cnt_a = cnt_a;
  assign bus.gnt_cnt_b = cnt_b;

  // Output register, fairness pointer, held select and grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      prio   <= SRC_A;
      sel_q  <= 1'b0;
      data_q <= '0;
      src_q  <= 1'b0;
      cnt_a  <= 8'd0;
      cnt_b  <= 8'd0;
    end else if (load) begin
      state  <= FULL;
      data_q <= mux_y;
      src_q  <= (winner == SRC_B);
      sel_q  <= (winner == SRC_B);
      prio   <= (winner == SRC_A) ? SRC_B : SRC_A;
      if (winner == SRC_A) begin
        cnt_a <= cnt_a + 8'd1;
      end else begin
        cnt_b <= cnt_b + 8'd1;
      end
    end else if ((state == FULL) && bus.out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_mux_arb_2x1.sv
// Directed and randomized bench for mux_arb_2x1 against a transaction-level model.
// Latency: checks registered outputs one cycle after each grant.
// Backpressure: drives out_ready low/high and checks grants are withheld while stalled.
module tb_mux_arb_2x1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic av = 1'b0, bv = 1'b0, ordy = 1'b0;
  logic [7:0] ad = 8'h00, bd = 8'h00;

  int checks = 0;
  int errors = 0;

  // Reference state: what the output register holds, whose turn it is, grant totals.
  bit         m_full;
  logic [7:0] m_data;
  bit         m_src;
  bit         m_sel;
  bit         m_prio;
  int         m_cnt_a;
  int         m_cnt_b;

  logic [7:0] seq_d [4];
  logic       seq_s [4];

  always #5 clk = ~clk;

  mux_arb_2x1_if #(.WIDTH(8)) bus ();

  assign bus.a_valid   = av;
  assign bus.a_data    = ad;
  assign bus.b_valid   = bv;
  assign bus.b_data    = bd;
  assign bus.out_ready = ordy;

  mux_arb_2x1 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check handshake outputs before the edge, then the registered state after it.
  task automatic step(input string tag);
    bit granted;
    bit who;
    bit exp_sel;
    #1;
    granted = 1'b0;
    who     = 1'b0;
    if (!rst && (!m_full || ordy) && (av || bv)) begin
      granted = 1'b1;
      if (av && bv) who = m_prio;
      else          who = bv;
    end
    exp_sel = rst ? 1'b0 : (granted ? who : m_sel);
    chk({tag, ".a_ready"}, bus.a_ready, granted && !who);
    chk({tag, ".b_ready"}, bus.b_ready, granted && who);
    chk({tag, ".sel"}, bus.sel, exp_sel);
    chk({tag, ".excl"}, bus.a_ready & bus.b_ready, 0);
    if (m_full && !ordy && !rst) chk({tag, ".stall_rdy"}, bus.a_ready | bus.b_ready, 0);
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_data = 8'h00; m_src = 0; m_sel = 0; m_prio = 0;
      m_cnt_a = 0; m_cnt_b = 0;
    end else if (granted) begin
      m_full = 1;
      m_data = who ? bd : ad;
      m_src  = who;
      m_sel  = who;
      m_prio = !who;
      if (who) m_cnt_b++;
      else     m_cnt_a++;
    end else if (m_full && ordy) begin
      m_full = 0;
    end
    #1;
    chk({tag, ".out_valid"}, bus.out_valid, m_full);
    chk({tag, ".out_data"}, bus.out_data, m_data);
    chk({tag, ".out_src"}, bus.out_src, m_src);
    chk({tag, ".gnt_cnt_a"}, bus.gnt_cnt_a, m_cnt_a % 256);
    chk({tag, ".gnt_cnt_b"}, bus.gnt_cnt_b, m_cnt_b % 256);
  endtask

  initial begin
    logic [7:0] exp_d [4];
    logic       exp_s [4];
    exp_d = '{8'h11, 8'h22, 8'h11, 8'h22};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
    m_full = 0; m_data = 0; m_src = 0; m_sel = 0; m_prio = 0; m_cnt_a = 0; m_cnt_b = 0;

    // Reset for two cycles, then every output must read zero.
    @(posedge clk); #1;
    rst = 1'b1;
    step("reset0");
    step("reset1");
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_data", bus.out_data, 0);
    chk("reset_cnts", {bus.gnt_cnt_a, bus.gnt_cnt_b}, 0);
    rst = 1'b0;
    step("idle");

    // Contention at full rate alternates A, B, A, B.
    av = 1; bv = 1; ad = 8'h11; bd = 8'h22; ordy = 1;
    for (int i = 0; i < 4; i++) begin
      step("contend");
      seq_d[i] = bus.out_data;
      seq_s[i] = bus.out_src;
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("contend_seq_data%0d", i), seq_d[i], exp_d[i]);
      chk($sformatf("contend_seq_src%0d", i), seq_s[i], exp_s[i]);
    end
    chk("contend_cnt_a", bus.gnt_cnt_a, 2);
    chk("contend_cnt_b", bus.gnt_cnt_b, 2);
    av = 0; bv = 0;
    step("drain0");

    // A alone with the sink stalled: one load, then the word holds and A waits.
    av = 1; ad = 8'hA5; ordy = 0;
    step("stall_load");
    step("stall1");
    chk("stall1_a_ready", bus.a_ready, 0);
    step("stall2");
    chk("stall_hold_data", bus.out_data, 8'hA5);
    ordy = 1; ad = 8'h5A;
    #1;
    chk("unstall_a_ready", bus.a_ready, 1);
    step("unstall");
    chk("unstall_data", bus.out_data, 8'h5A);
    av = 0;
    step("drain1");

    // 300 grants to A only: counter wraps to 44, B stays zero.
    rst = 1;
    step("rst_for_wrap");
    rst = 0; av = 1; ordy = 1;
    for (int i = 0; i < 300; i++) begin
      ad = 8'($urandom);
      step("wrap");
    end
    chk("wrap_cnt_a", bus.gnt_cnt_a, 44);
    chk("wrap_cnt_b", bus.gnt_cnt_b, 0);
    av = 0;
    step("drain2");

    // Reset while holding 3C discards it and restores A-first priority.
    av = 1; ad = 8'h3C; ordy = 0;
    step("hold_3c");
    chk("hold_3c_data", bus.out_data, 8'h3C);
    av = 0; rst = 1;
    step("rst_full");
    chk("rst_full_valid", bus.out_valid, 0);
    chk("rst_full_data", bus.out_data, 0);
    rst = 0; av = 1; bv = 1; ad = 8'h01; bd = 8'h02; ordy = 1;
    step("post_rst_contend");
    chk("post_rst_first_src", bus.out_src, 0);
    chk("post_rst_first_data", bus.out_data, 8'h01);

    // Random traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      av   = 1'($urandom);
      bv   = 1'($urandom);
      ad   = 8'($urandom);
      bd   = 8'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 59) == 0);
      step("rand");
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
